// File: rtl/iq_cic_pkg.sv
// Shared definitions for the dual-channel CIC decimator.
//   acc_width() : integrator/comb register width, INPUT_WIDTH + STAGES*CNT_WIDTH
//   sh_width()  : width of the SHIFT control, clog2 of the accumulator width
//   warm_state_t: warm-up state (WARM while the comb delays fill, then RUN)
//   saturate()  : clamp a wide signed value to an out_w-bit signed range
// The rounding build option CIC_ROUND_EN is handled in cic_decim_channel.
package iq_cic_pkg;

    // Working width of saturate(); must be at least ACC_W+1.
    localparam int SAT_W = 128;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } warm_state_t;

    function automatic int acc_width(input int in_w, input int stages, input int cnt_w);
        return in_w + stages * cnt_w;
    endfunction

    function automatic int sh_width(input int acc_w);
        return $clog2(acc_w);
    endfunction

    // Result is still SAT_W wide; the caller truncates to out_w bits.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                          input int out_w);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = {{(SAT_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (out_w - 1)) - one;
        lo  = -(one <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cic_decim_channel.sv
// One CIC channel: STAGES integrators, capture register, STAGES pipelined
// combs and the registered shift/round/saturate output stage.
// Build option: CIC_ROUND_EN adds round-half-up before the shift; without
// it the shift truncates (floor).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_in_valid     i_data accepted this cycle (integrators advance)
//   i_data         signed input sample
//   i_cap          capture strobe (already qualified by i_in_valid)
//   i_shift        right shift aligned with the last comb stage output
//   o_data         registered, saturated output sample
module cic_decim_channel
    import iq_cic_pkg::*;
#(
    parameter  int CNT_WIDTH    = 8,
    parameter  int INPUT_WIDTH  = 12,
    parameter  int OUTPUT_WIDTH = 12,
    parameter  int STAGES       = 4,
    localparam int ACC_W        = acc_width(INPUT_WIDTH, STAGES, CNT_WIDTH),
    localparam int SH_W         = sh_width(ACC_W)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_in_valid,
    input  logic signed [INPUT_WIDTH-1:0]  i_data,
    input  logic                           i_cap,
    input  logic        [SH_W-1:0]         i_shift,
    output logic signed [OUTPUT_WIDTH-1:0] o_data
);

    logic signed [ACC_W-1:0]        r_integ    [STAGES];
    logic signed [ACC_W-1:0]        r_cap;
    logic signed [ACC_W-1:0]        r_comb     [STAGES];
    logic signed [ACC_W-1:0]        r_dly      [STAGES];
    logic        [STAGES:0]         r_cv;
    logic signed [OUTPUT_WIDTH-1:0] r_out;

    logic signed [ACC_W-1:0]        w_in_ext;
    logic signed [ACC_W-1:0]        w_stage_in [STAGES];
    logic signed [ACC_W:0]          w_pre;
    logic signed [ACC_W:0]          w_shifted;
    logic signed [SAT_W-1:0]        w_wide;
`ifdef CIC_ROUND_EN
    logic signed [ACC_W:0]          w_bias;
`endif

    assign w_in_ext = {{(ACC_W-INPUT_WIDTH){i_data[INPUT_WIDTH-1]}}, i_data};

    always_comb begin
        w_stage_in[0] = r_cap;
        for (int k = 1; k < STAGES; k++) begin
            w_stage_in[k] = r_comb[k-1];
        end
    end

    // One extra bit of headroom so the rounding bias cannot wrap.
    always_comb begin
        w_pre = {r_comb[STAGES-1][ACC_W-1], r_comb[STAGES-1]};
`ifdef CIC_ROUND_EN
        w_bias = '0;
        if (i_shift != '0) begin
            w_bias = {{ACC_W{1'b0}}, 1'b1} <<< (i_shift - 1'b1);
        end
        w_pre = w_pre + w_bias;
`endif
        w_shifted = w_pre >>> i_shift;
        w_wide    = {{(SAT_W-ACC_W-1){w_shifted[ACC_W]}}, w_shifted};
    end

    // Integrators wrap freely; the comb differences undo the wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_integ[k] <= '0;
            end
        end else if (i_in_valid) begin
            r_integ[0] <= r_integ[0] + w_in_ext;
            for (int k = 1; k < STAGES; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // r_cv[k] marks that comb stage k has fresh input this cycle; comb
    // delay registers move only with a capture flowing through.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cap <= '0;
            r_cv  <= '0;
            r_out <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_comb[k] <= '0;
                r_dly[k]  <= '0;
            end
        end else begin
            r_cv[0] <= i_cap;
            if (i_cap) begin
                r_cap <= r_integ[STAGES-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_cv[k+1] <= r_cv[k];
                if (r_cv[k]) begin
                    r_comb[k] <= w_stage_in[k] - r_dly[k];
                    r_dly[k]  <= w_stage_in[k];
                end
            end
            if (r_cv[STAGES]) begin
                r_out <= OUTPUT_WIDTH'(saturate(w_wide, OUTPUT_WIDTH));
            end
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/iq_cic_decimator.sv
// Dual-channel (I/Q) CIC decimator with run-time ratio and output shift.
// Holds the shared frame counter, N/SHIFT latching, warm-up FSM and the
// valid/shift alignment pipeline; the two channels share one capture
// strobe so I and Q stay sample-aligned.
// Build option: CIC_ROUND_EN (round-half-up before the shift, see channel).
// Ports:
//   clk_in, RST     clock, synchronous active-high reset
//   N               decimation ratio, 0 and 1 both mean every sample
//   SHIFT           arithmetic right shift before saturation
//   in_valid        I_IN/Q_IN valid
//   out_valid       one-cycle strobe with I_OUT/Q_OUT
//
//   state | meaning
//   WARM  | first STAGES captures flush comb delays, no output
//   RUN   | every capture produces an output
module iq_cic_decimator
    import iq_cic_pkg::*;
#(
    parameter  int CNT_WIDTH    = 8,
    parameter  int INPUT_WIDTH  = 12,
    parameter  int OUTPUT_WIDTH = 12,
    parameter  int STAGES       = 4,
    localparam int ACC_W        = acc_width(INPUT_WIDTH, STAGES, CNT_WIDTH),
    localparam int SH_W         = sh_width(ACC_W)
) (
    input  logic                           clk_in,
    input  logic                           RST,
    input  logic        [CNT_WIDTH-1:0]    N,
    input  logic        [SH_W-1:0]         SHIFT,
    input  logic                           in_valid,
    input  logic signed [INPUT_WIDTH-1:0]  I_IN,
    input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] I_OUT,
    output logic signed [OUTPUT_WIDTH-1:0] Q_OUT
);

    localparam int WC_W = $clog2(STAGES + 1);

    logic [CNT_WIDTH-1:0] r_n_lat;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [SH_W-1:0]      r_shift_lat;
    warm_state_t          r_state;
    logic [WC_W-1:0]      r_warm_cnt;
    logic [STAGES:0]      r_emit;
    logic [SH_W-1:0]      r_sh_pipe [STAGES+1];
    logic                 r_out_valid;

    logic [CNT_WIDTH-1:0] w_last_idx;
    logic                 w_cap;
    logic                 w_warm_done;
    logic                 w_emit;
    warm_state_t          w_state_nxt;

    assign w_last_idx  = (r_n_lat <= CNT_WIDTH'(1)) ? '0 : r_n_lat - 1'b1;
    assign w_cap       = in_valid && (r_frame_cnt == w_last_idx);
    assign w_warm_done = (r_warm_cnt == WC_W'(STAGES));

    // N/SHIFT are loaded while RST is held so the first frame after release
    // uses the values present at release.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            r_frame_cnt <= '0;
            r_n_lat     <= N;
            r_shift_lat <= SHIFT;
        end else if (in_valid) begin
            if (w_cap) begin
                r_frame_cnt <= '0;
                r_n_lat     <= N;
                r_shift_lat <= SHIFT;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            r_state    <= WARM;
            r_warm_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cap && (r_state == WARM) && !w_warm_done) begin
                r_warm_cnt <= r_warm_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WARM:    if (w_cap && w_warm_done) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = WARM;
        endcase
    end

    always_comb begin
        w_emit = 1'b0;
        case (r_state)
            WARM:    w_emit = w_cap && w_warm_done;
            RUN:     w_emit = w_cap;
            default: w_emit = 1'b0;
        endcase
    end

    // The shift travels with its capture so a SHIFT reload at a frame wrap
    // never touches a result still inside the combs.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            r_emit      <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                r_sh_pipe[k] <= '0;
            end
        end else begin
            r_emit[0]    <= w_emit;
            r_sh_pipe[0] <= r_shift_lat;
            for (int k = 0; k < STAGES; k++) begin
                r_emit[k+1]    <= r_emit[k];
                r_sh_pipe[k+1] <= r_sh_pipe[k];
            end
            r_out_valid <= r_emit[STAGES];
        end
    end

    assign out_valid = r_out_valid;

    cic_decim_channel #(
        .CNT_WIDTH   (CNT_WIDTH),
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .STAGES      (STAGES)
    ) u_chan_i (
        .i_clk      (clk_in),
        .i_rst      (RST),
        .i_in_valid (in_valid),
        .i_data     (I_IN),
        .i_cap      (w_cap),
        .i_shift    (r_sh_pipe[STAGES]),
        .o_data     (I_OUT)
    );

    cic_decim_channel #(
        .CNT_WIDTH   (CNT_WIDTH),
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .STAGES      (STAGES)
    ) u_chan_q (
        .i_clk      (clk_in),
        .i_rst      (RST),
        .i_in_valid (in_valid),
        .i_data     (Q_IN),
        .i_cap      (w_cap),
        .i_shift    (r_sh_pipe[STAGES]),
        .o_data     (Q_OUT)
    );

endmodule

// File: doc/iq_cic_decimator.md
Name: iq_cic_decimator

Overview:
Dual-channel (I/Q) CIC decimator with run-time decimation ratio and gain normalisation.
- Stage count and widths are parametrised.
- Input samples are accepted on a valid qualifier.
- Decimated output is a one-cycle valid strobe on the same clock; there is no derived output clock.
- Sits between the digital down-converter mixer and the audio/demod back end.

Parameters:
CNT_WIDTH, 8, width of decimation-ratio port N; max ratio 2^CNT_WIDTH-1
INPUT_WIDTH, 12, signed two's-complement input sample width
OUTPUT_WIDTH, 12, signed output sample width
STAGES, 4, number of integrator and comb stages (1..6); differential delay fixed at 1

Ports:
clk_in  in  1  sole clock
RST  in  1  synchronous, active-high reset
N  in  CNT_WIDTH  decimation ratio (unsigned)
SHIFT  in  SH_W  arithmetic right shift applied before output; SH_W = clog2(ACC_W)
in_valid  in  1  I_IN/Q_IN valid this cycle
I_IN  in  INPUT_WIDTH  signed I sample
Q_IN  in  INPUT_WIDTH  signed Q sample
out_valid  out  1  one-cycle strobe, I_OUT/Q_OUT valid
I_OUT  out  OUTPUT_WIDTH  signed decimated I
Q_OUT  out  OUTPUT_WIDTH  signed decimated Q

Behaviour:
- Width rule: ACC_W = INPUT_WIDTH + STAGES*CNT_WIDTH. All integrator and comb registers are ACC_W wide.
- Arithmetic: two's-complement wrap-around with no saturation inside the integrators and combs. Wrap-around is required for correctness.
- Integrators:
  - Cascade of STAGES registered accumulators. Stage k adds the registered output of stage k-1; stage 0 adds the sign-extended input.
  - They advance only on cycles with in_valid=1 and hold otherwise.
- Frame counter:
  - Counts accepted samples 0..R-1, where R = N_lat.
  - N_lat and SHIFT_lat are latched at reset release and at each frame wrap. Mid-frame changes of N/SHIFT take effect at the next frame boundary.
  - N=0 or N=1 gives R=1: every accepted sample produces an output.
- Capture: on the edge accepting the R-th sample of a frame, the final integrator value is captured into the comb pipeline (capture edge C).
- Combs:
  - STAGES pipelined stages, one register each.
  - Each stage subtracts its own previous-capture value. Comb delay registers update only on capture events.
- Output stage:
  - Computes comb result >>> SHIFT_lat (arithmetic), then saturates to the OUTPUT_WIDTH signed range: max 2^(OUTPUT_WIDTH-1)-1, min -2^(OUTPUT_WIDTH-1).
  - The result is registered.
- Latency: out_valid rises on edge C+STAGES+1 and is high for exactly one cycle per frame.
- Back-to-back captures (R=1, continuous in_valid) are fully pipelined: one output per cycle.
- Warm-up state machine:
  - States: WARM → RUN.
  - After reset, state is WARM. The first STAGES captures flush the comb delays and produce no out_valid.
  - The (STAGES+1)-th capture moves the state to RUN; that capture and all later ones produce out_valid.
- Reset values: all integrators, combs, frame counter, warm-up counter = 0; state = WARM; out_valid=0; I_OUT=Q_OUT=0.
- Reset mid-frame: all state is cleared on that edge and any in-flight pipeline outputs are discarded. Warm-up restarts.
- I and Q share the frame counter, capture strobe and warm-up control, so their outputs are always sample-aligned.

Optional Feature:
Macro: CIC_ROUND_EN.
- Defined: round-half-up before the shift. Add 2^(SHIFT_lat-1) when SHIFT_lat>0, in ACC_W+1 bits, then shift and saturate.
- Undefined: truncation (floor) by the arithmetic shift only.
- Latency is identical in both builds.

Decomposition:
Package iq_cic_pkg holds:
- the ACC_W and SH_W constant functions;
- the warm-up state enum (WARM, RUN);
- the saturate helper function.

Sub-module cic_decim_channel holds one channel's integrators, combs and shift/round/saturate output, driven by a shared capture strobe. It is instantiated twice (I, Q). The top level holds the frame counter, N/SHIFT latching and the warm-up FSM.

Test Plan:
- DC gain: STAGES=4, N=4, SHIFT=8, I_IN=1, Q_IN=-1, in_valid=1 continuous.
  → No out_valid for the first 4 captures; afterwards I_OUT=1, Q_OUT=-1, out_valid every 4 cycles.
- Saturation: N=16, SHIFT=8, I_IN=2047, Q_IN=-2048.
  → Steady state I_OUT=2047, Q_OUT=-2048 (clamped).
- Rounding: N=2, SHIFT=5, I_IN=3 (gain 16 gives 48, i.e. 1.5 after the shift).
  → Without CIC_ROUND_EN: I_OUT=1. With CIC_ROUND_EN: I_OUT=2.
- Gapped input: N=4, SHIFT=8, in_valid toggling 1/0.
  → Same values as the DC gain case; out_valid every 8 cycles, exactly STAGES+1 cycles after each capture edge.
- Ratio change mid-frame: N changed from 4 to 8 after 2 accepted samples.
  → Current frame completes at 4 samples; subsequent frames span 8 samples.
- Reset mid-frame: assert RST for 1 cycle during a run.
  → Next cycle all outputs are 0 and out_valid=0; the next 4 captures are suppressed, then correct values resume.
